// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared widths and controller state encoding for mem_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } mem_ctrl_state_t;

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module  : mem_ctrl
// Brief   : Request/response controller for a single-port synchronous memory
//           with 1-cycle registered read; single writes and 1..8 beat reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  // request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              wr_done,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  mem_ctrl_state_t   state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              issue_en;
  logic              issue_we;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    wdata_d      = wdata_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_last     = 1'b0;
    issue_en     = 1'b0;
    issue_we     = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cur_addr_d   = req_addr;
          wdata_d      = req_wdata;
          beats_left_d = req_len;
          state_d      = req_we ? WRITE : READ;
        end
      end
      WRITE: begin
        issue_en = 1'b1;
        issue_we = 1'b1;
        state_d  = IDLE;
      end
      READ: begin
        issue_en = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        // memory holds dout while idle, so the beat stays stable under stall
        rsp_valid = 1'b1;
        rsp_last  = (beats_left_q == '0);
        if (rsp_ready) begin
          if (rsp_last) begin
            state_d = IDLE;
          end else begin
            cur_addr_d   = cur_addr_q + ADDR_W'(1);
            beats_left_d = beats_left_q - LEN_W'(1);
            state_d      = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      wdata_q      <= wdata_d;
    end
  end

  // Gating with rst keeps the memory untouched in any reset cycle.
  assign mem_en   = issue_en & ~rst;
  assign mem_we   = issue_we & ~rst;
  assign wr_done  = issue_we & ~rst;
  assign mem_addr = cur_addr_q;
  assign mem_din  = wdata_q;
  assign rsp_data = mem_dout;
  assign busy     = (state_q != IDLE);

endmodule : mem_ctrl

`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Initiator-side controller for the 32x8 single-port synchronous memory (en/we/addr/din/dout; 1-cycle registered read; dout holds while not reading).
- Accepts single-beat write requests and burst read requests (1..8 beats) from the core over a valid/ready request channel.
- Drives the memory port and returns read data on a valid/ready response channel with a last-beat flag.
- Sits between the CPU datapath and the memory instance.

Parameters:
ADDR_W, 5, memory address width (depth 2**ADDR_W)
DATA_W, 8, data width
LEN_W, 3, burst length field width; beats = req_len + 1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = write (single beat), 0 = read burst
req_addr  input  ADDR_W  start address
req_len  input  LEN_W  read beats minus 1 (ignored for writes)
req_wdata  input  DATA_W  write data
wr_done  output  1  one-cycle pulse: write issued to memory this cycle
rsp_valid  output  1  read beat available
rsp_ready  input  1  consumer accepts read beat
rsp_data  output  DATA_W  read beat data
rsp_last  output  1  final beat of burst (valid with rsp_valid)
busy  output  1  state != IDLE
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_din  output  DATA_W  memory write data
mem_dout  input  DATA_W  memory read data (valid cycle after en&!we)

Behaviour:
- States: IDLE, WRITE, READ, RESP. Encoded as an enum; state, cur_addr, beats_left, wdata_q are registered.
- Reset (sync, rst=1 at edge): state=IDLE, cur_addr=0, beats_left=0, wdata_q=0.
  - Outputs after reset: req_ready=1, rsp_valid=0, rsp_last=0, wr_done=0, busy=0, mem_en=0, mem_we=0.
  - mem_en, mem_we and wr_done are gated with !rst, so no memory access occurs in any cycle where rst=1, including reset mid-WRITE or mid-burst.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch req_addr->cur_addr, req_wdata->wdata_q, req_len->beats_left.
  - Next state is WRITE if req_we, else READ.
- WRITE (1 cycle):
  - mem_en=1, mem_we=1, mem_addr=cur_addr, mem_din=wdata_q, wr_done=1.
  - Next IDLE. Request-to-memory-write latency is 1 cycle after the handshake.
- READ (1 cycle):
  - mem_en=1, mem_we=0, mem_addr=cur_addr.
  - Next RESP.
- RESP:
  - mem_en=0; rsp_valid=1; rsp_data=mem_dout, which is stable because the memory holds dout.
  - rsp_last = (beats_left==0).
  - If rsp_ready && rsp_last: next IDLE.
  - If rsp_ready && !rsp_last: cur_addr <= cur_addr+1 (mod 2**ADDR_W, so 31->0), beats_left <= beats_left-1, next READ.
  - If !rsp_ready: stay in RESP; rsp_data and rsp_last hold.
- Throughput: 1 read beat per 2 cycles at best. First rsp_valid appears 2 cycles after the request handshake.
- req_ready=0 in all states except IDLE. A request presented while busy is not accepted and must be held by the source.
- Outside WRITE: mem_we=0, mem_din=wdata_q, mem_addr=cur_addr.
- No back-to-back request acceptance in the same cycle a burst ends; IDLE is always visited for at least 1 cycle.

Decomposition:
- Package mem_pkg: ADDR_W, DATA_W, LEN_W constants, and typedef enum logic [1:0] mem_ctrl_state_t {IDLE, WRITE, READ, RESP}.
- No sub-module; address and beat counters are inline.

Test Plan:
- Write 0xA5 to addr 3 -> one cycle later mem_en=1, mem_we=1, mem_addr=3, mem_din=0xA5, wr_done pulse. Then read addr 3 len 0 -> rsp_data=0xA5 with rsp_last=1, 2 cycles after handshake.
- Preload addrs 2..5 = 0x10,0x11,0x12,0x13; read addr 2 req_len=3, rsp_ready=1 -> 4 beats 0x10..0x13 every 2 cycles, rsp_last only on 0x13, then IDLE.
- Burst wrap: read addr 30 req_len=3 -> mem_addr sequence 30,31,0,1; data matches preload.
- Backpressure: during a 2-beat burst, hold rsp_ready=0 for 3 cycles on beat 0 -> rsp_valid stays 1, rsp_data constant, mem_en=0 throughout the stall; beat 1 follows after release.
- Request while busy: assert a write request during a burst -> req_ready=0, no mem_we. The write is accepted in the first IDLE cycle after the burst.
- Reset mid-burst: assert rst during READ of beat 2 of 4 -> mem_en=0 in the reset cycle. Next cycle rsp_valid=0, busy=0, req_ready=1, and no further beats are emitted.
